// File: rtl/dcache_flush_arbiter.sv
// Round-robin arbiter sharing the single DCache flush port among NUM_REQ requesters.
// Optional flush watchdog enabled by defining FLUSH_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | no flush in flight, arbitrate pending requests
//   FLUSH  | flush_dcache_o high, waiting for cache ack
//   DRAIN  | flush acked, waiting for outstanding cache transactions
//   DONE   | done_o pulse to granted requester, advance round-robin pointer
module dcache_flush_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic               err_o,
    output logic               busy_o,
    output logic               flush_dcache_o,
    input  logic               flush_dcache_ack_i,
    input  logic               cache_busy_i
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt, w_pick;
    logic [PW-1:0]      w_gidx;
    logic               r_flush;
    logic               w_tmo;

    // Scan from the far end so the requester closest to r_ptr overwrites the others.
    always_comb begin
        w_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[PW'((int'(r_ptr) + i) % NUM_REQ)]) begin
                w_pick = '0;
                w_pick[PW'((int'(r_ptr) + i) % NUM_REQ)] = 1'b1;
            end
        end
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_gidx = PW'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|req_i) begin
                    w_state_nxt = S_FLUSH;
                    w_grant_nxt = w_pick;
                end
            end
            S_FLUSH: begin
                if (flush_dcache_ack_i) w_state_nxt = cache_busy_i ? S_DRAIN : S_DONE;
                else if (w_tmo)         w_state_nxt = S_DONE;
            end
            S_DRAIN: begin
                if (!cache_busy_i || w_tmo) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_ptr_nxt   = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + PW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_flush <= (w_state_nxt == S_FLUSH);
        end
    end

`ifdef FLUSH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_timer;
    logic          r_err;
    logic          w_err_nxt;

    assign w_tmo = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    // A normal completion in the expiry cycle wins, so err only on the watchdog path.
    assign w_err_nxt = w_tmo && (((r_state == S_FLUSH) && !flush_dcache_ack_i) ||
                                 ((r_state == S_DRAIN) && cache_busy_i));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
            if ((r_state == S_FLUSH) || (r_state == S_DRAIN)) r_timer <= r_timer + TW'(1);
            else                                              r_timer <= '0;
        end
    end

    assign err_o = (r_state == S_DONE) && r_err;
`else
    assign w_tmo = 1'b0;
    assign err_o = 1'b0;
`endif

    assign busy_o         = (r_state != S_IDLE);
    assign gnt_o          = busy_o ? r_grant : '0;
    assign done_o         = (r_state == S_DONE) ? r_grant : '0;
    assign flush_dcache_o = r_flush;

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// Self-checking bench for dcache_flush_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a transaction-level reference model.
module tb_dcache_flush_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [N-1:0] req_i;
    logic [N-1:0] gnt_o;
    logic [N-1:0] done_o;
    logic         err_o;
    logic         busy_o;
    logic         flush_dcache_o;
    logic         flush_dcache_ack_i;
    logic         cache_busy_i;

    dcache_flush_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_i              (req_i),
        .gnt_o              (gnt_o),
        .done_o             (done_o),
        .err_o              (err_o),
        .busy_o             (busy_o),
        .flush_dcache_o     (flush_dcache_o),
        .flush_dcache_ack_i (flush_dcache_ack_i),
        .cache_busy_i       (cache_busy_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: which requester is being served and where it is in its flush.
    int m_cur   = -1;
    bit m_drain = 0;
    bit m_done  = 0;
    bit m_err   = 0;
    int m_ptr   = 0;
    int m_age   = 0;
    logic [N-1:0] t_req;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic bit timeout_en();
`ifdef FLUSH_TIMEOUT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_advance(input logic [N-1:0] req, input bit ack, input bit cb, input bit rst);
        bit finish;
        if (!rst) begin
            m_cur = -1; m_drain = 0; m_done = 0; m_err = 0; m_ptr = 0; m_age = 0;
        end else if (m_cur < 0) begin
            if (req != 0) begin
                m_cur = rr_pick(req, m_ptr); m_drain = 0; m_done = 0; m_err = 0; m_age = 0;
            end
        end else if (m_done) begin
            m_ptr = (m_cur + 1) % N; m_cur = -1; m_done = 0; m_err = 0;
        end else begin
            finish = m_drain ? !cb : ack;
            if (!m_drain && ack && cb)            m_drain = 1;
            else if (finish)                       m_done = 1;
            else if (timeout_en() && m_age == TO - 1) begin m_done = 1; m_err = 1; end
            m_age++;
        end
    endtask

    task automatic step(input logic [N-1:0] req, input bit ack, input bit cb, input bit rst);
        logic [31:0] e_gnt, e_done;
        @(negedge clk_i);
        e_gnt  = (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0;
        e_done = (m_cur >= 0 && m_done) ? (32'd1 << m_cur) : 32'd0;
        chk("busy",  32'(busy_o), 32'(m_cur >= 0));
        chk("gnt",   32'(gnt_o), e_gnt);
        chk("done",  32'(done_o), e_done);
        chk("flush", 32'(flush_dcache_o), 32'(m_cur >= 0 && !m_drain && !m_done));
        chk("err",   32'(err_o), 32'(m_done && m_err));
        req_i              = req;
        flush_dcache_ack_i = ack;
        cache_busy_i       = cb;
        rst_ni             = rst;
        @(posedge clk_i);
        model_advance(req, ack, cb, rst);
    endtask

    // One full flush: arbitrate, ack after ack_dly cycles, drain nbusy cycles, done.
    task automatic serve(input int exp_g, input int ack_dly, input int nbusy);
        step(t_req, 0, 0, 1);
        #1 chk("sv_gnt", 32'(gnt_o), 32'd1 << exp_g);
        repeat (ack_dly) step(t_req, 0, 0, 1);
        step(t_req, 1, nbusy > 0, 1);
        if (nbusy > 0) begin
            repeat (nbusy - 1) step(t_req, 0, 1, 1);
            #1 chk("sv_drain_flush", 32'(flush_dcache_o), 32'd0);
            step(t_req, 0, 0, 1);
        end
        #1 chk("sv_done", 32'(done_o), 32'd1 << exp_g);
        t_req[exp_g] = 1'b0;
        step(t_req, 0, 0, 1);
        #1 chk("sv_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        bit ack, cb, rst;
        rst_ni = 1'b0; req_i = '0; flush_dcache_ack_i = 1'b0; cache_busy_i = 1'b0;
        t_req = '0;
        repeat (2) @(posedge clk_i);
        model_advance('0, 0, 0, 0);
        #1;
        chk("rst_busy",  32'(busy_o), 32'd0);
        chk("rst_gnt",   32'(gnt_o), 32'd0);
        chk("rst_flush", 32'(flush_dcache_o), 32'd0);
        step('0, 0, 0, 1);

        t_req = 4'b0001; serve(0, 5, 0);
        t_req = 4'b0011; serve(1, 1, 0);

        step('0, 0, 0, 0);
        t_req = 4'b0101; serve(0, 2, 0);
        serve(2, 0, 4);
        t_req = 4'b1001; serve(3, 1, 0);
        serve(0, 3, 2);

        t_req = 4'b0001;
        step(t_req, 0, 0, 1);
        step(t_req, 0, 0, 1);
        step(t_req, 0, 0, 0);
        #1;
        chk("rst_mid_flush", 32'(flush_dcache_o), 32'd0);
        chk("rst_mid_done",  32'(done_o), 32'd0);
        t_req = '0;
        step('0, 1, 0, 1);
        #1 chk("ack_idle_busy", 32'(busy_o), 32'd0);

`ifdef FLUSH_TIMEOUT_EN
        t_req = 4'b0100;
        step(t_req, 0, 0, 1);
        repeat (TO) step(t_req, 0, 0, 1);
        #1;
        chk("tmo_done", 32'(done_o), 32'b0100);
        chk("tmo_err",  32'(err_o), 32'd1);
        t_req = '0;
        step(t_req, 0, 0, 1);
`endif

        for (int c = 0; c < 3000; c++) begin
            if (m_cur >= 0 && m_done) t_req[m_cur] = 1'b0;
            else if (m_cur >= 0 && $urandom_range(0, 63) == 0) t_req[m_cur] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!t_req[i] && $urandom_range(0, 3) == 0) t_req[i] = 1'b1;
            ack = ($urandom_range(0, 3) == 0);
            cb  = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 399) != 0);
            if (!rst) t_req = '0;
            step(t_req, ack, cb, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
